dma_ctrl: RTL and testbench



---
 rtl/dma_ctrl_if.sv | 12 +
 rtl/dma_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_dma_ctrl.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_ctrl_if.sv
// Byte bus between a requester and a responder: din flows toward the responder,
// dout comes back. Used for both the CPU side and the memory side of dma_ctrl.
interface dma_ctrl_if;
    logic [7:0]  din;
    logic [15:0] address;
    logic        w_en;
    logic        r_en;
    logic [7:0]  dout;

    modport master (output din, output address, output w_en, output r_en, input dout);
    modport slave  (input din, input address, input w_en, input r_en, output dout);
endinterface

// File: rtl/dma_ctrl.sv
// Byte-copy DMA engine between the CPU data port and the data-memory/IO bus.
// Optional build macro DMA_FILL_EN adds CTRL bit2 FILL: one SRC_L byte written per cycle.
module dma_ctrl #(
    parameter logic [7:0] DMA_ADDRESS = 8'h90
) (
    input  logic       clk,
    input  logic       rst,
    dma_ctrl_if.slave  cpu,
    dma_ctrl_if.master mem,
    output logic       cpu_stall,
    output logic       done_flag,
    input  logic       done_flag_clr
);
    localparam logic [15:0] REG_BASE = 16'h1000 + {8'h00, DMA_ADDRESS};

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;

    state_t      state_q;
    logic [15:0] src_q;
    logic [15:0] dst_q;
    logic [7:0]  len_q;
    logic        dst_fixed_q;
    logic [15:0] wsrc_q;
    logic [15:0] wdst_q;
    logic [8:0]  cnt_q;
    logic        done_q;
    logic [7:0]  rd_data_q;
    logic        rd_hit_q;

    logic [15:0] reg_off;
    logic [2:0]  reg_idx;
    logic        reg_hit;
    logic        idle;
    logic        reg_wr;
    logic        reg_rd;
    logic        start;
    logic        start_fill;
    logic        fill_en;
    logic [7:0]  status;
    logic [7:0]  reg_rdata;

    // Unsigned offset from the base; anything outside 0..5 (including below base) misses.
    assign reg_off = cpu.address - REG_BASE;
    assign reg_idx = reg_off[2:0];
    assign reg_hit = (reg_off < 16'd6);
    assign idle    = (state_q == S_IDLE);
    assign reg_wr  = idle && cpu.w_en && reg_hit;
    assign reg_rd  = idle && cpu.r_en && reg_hit;
    assign start   = reg_wr && (reg_idx == 3'd5) && cpu.din[0];

`ifdef DMA_FILL_EN
    logic fill_q;
    assign fill_en    = fill_q;
    assign start_fill = cpu.din[2];
`else
    assign fill_en    = 1'b0;
    assign start_fill = 1'b0;
`endif

    assign status = {5'b00000, fill_en, done_q, ~idle};

    always_comb begin
        reg_rdata = status;
        case (reg_idx)
            3'd0:    reg_rdata = src_q[7:0];
            3'd1:    reg_rdata = src_q[15:8];
            3'd2:    reg_rdata = dst_q[7:0];
            3'd3:    reg_rdata = dst_q[15:8];
            3'd4:    reg_rdata = len_q;
            default: reg_rdata = status;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            src_q       <= 16'h0000;
            dst_q       <= 16'h0000;
            len_q       <= 8'h00;
            dst_fixed_q <= 1'b0;
            wsrc_q      <= 16'h0000;
            wdst_q      <= 16'h0000;
            cnt_q       <= 9'd0;
            done_q      <= 1'b0;
            rd_data_q   <= 8'h00;
            rd_hit_q    <= 1'b0;
`ifdef DMA_FILL_EN
            fill_q      <= 1'b0;
`endif
        end else begin
            rd_hit_q <= reg_rd;
            if (reg_rd) begin
                rd_data_q <= reg_rdata;
            end

            if (reg_wr) begin
                case (reg_idx)
                    3'd0:    src_q[7:0]  <= cpu.din;
                    3'd1:    src_q[15:8] <= cpu.din;
                    3'd2:    dst_q[7:0]  <= cpu.din;
                    3'd3:    dst_q[15:8] <= cpu.din;
                    3'd4:    len_q       <= cpu.din;
                    default: begin
                        dst_fixed_q <= cpu.din[1];
`ifdef DMA_FILL_EN
                        fill_q      <= cpu.din[2];
`endif
                    end
                endcase
            end

            // Completion wins over a same-cycle clear so the interrupt is never lost.
            if (state_q == S_WRITE && cnt_q == 9'd1) begin
                done_q <= 1'b1;
            end else if (done_flag_clr) begin
                done_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        wsrc_q  <= src_q;
                        wdst_q  <= dst_q;
                        cnt_q   <= (len_q == 8'h00) ? 9'd256 : {1'b0, len_q};
                        state_q <= start_fill ? S_WRITE : S_READ;
                    end
                end
                S_READ: begin
                    state_q <= S_WRITE;
                end
                S_WRITE: begin
                    wsrc_q <= wsrc_q + 16'd1;
                    if (!dst_fixed_q) begin
                        wdst_q <= wdst_q + 16'd1;
                    end
                    cnt_q <= cnt_q - 9'd1;
                    if (cnt_q == 9'd1) begin
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= fill_en ? S_WRITE : S_READ;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Bus is muxed straight from state so READ/WRITE cost no extra cycle.
    always_comb begin
        mem.address = cpu.address;
        mem.din     = cpu.din;
        mem.w_en    = cpu.w_en && !reg_hit;
        mem.r_en    = cpu.r_en && !reg_hit;
        cpu_stall   = 1'b0;
        case (state_q)
            S_READ: begin
                mem.address = wsrc_q;
                mem.din     = 8'h00;
                mem.w_en    = 1'b0;
                mem.r_en    = 1'b1;
                cpu_stall   = 1'b1;
            end
            S_WRITE: begin
                mem.address = wdst_q;
                mem.din     = fill_en ? src_q[7:0] : mem.dout;
                mem.w_en    = 1'b1;
                mem.r_en    = 1'b0;
                cpu_stall   = 1'b1;
            end
            default: begin
                cpu_stall = 1'b0;
            end
        endcase
    end

    assign cpu.dout  = rd_hit_q ? rd_data_q : mem.dout;
    assign done_flag = done_q;
endmodule

// File: tb/tb_dma_ctrl.sv
// Directed-plus-random bench for dma_ctrl: expected bus traffic is derived from
// the block-copy rules over a reference memory image.
module tb_dma_ctrl;
    localparam logic [15:0] BASE = 16'h1090;
`ifdef DMA_FILL_EN
    localparam bit FILL_EN = 1'b1;
`else
    localparam bit FILL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic done_flag_clr = 1'b0;
    logic done_flag;
    logic cpu_stall;

    dma_ctrl_if cpu_bus ();
    dma_ctrl_if mem_bus ();

    dma_ctrl #(.DMA_ADDRESS(8'h90)) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu          (cpu_bus),
        .mem          (mem_bus),
        .cpu_stall    (cpu_stall),
        .done_flag    (done_flag),
        .done_flag_clr(done_flag_clr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] init_byte(input logic [15:0] a);
        return (a[7:0] * 8'd7) ^ a[15:8] ^ 8'h5C;
    endfunction

    // Data RAM / IO responder with one-cycle registered read.
    logic [7:0] ram [0:65535];
    logic [7:0] ram_rdata;
    assign mem_bus.dout = ram_rdata;
    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = init_byte(16'(i));
        ram_rdata = 8'h00;
        forever begin
            @(posedge clk);
            if (rst) begin
                ram_rdata <= 8'h00;
            end else begin
                if (mem_bus.w_en) ram[mem_bus.address] <= mem_bus.din;
                if (mem_bus.r_en) ram_rdata <= ram[mem_bus.address];
            end
        end
    end

    logic [7:0] exp_mem [0:65535];
    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        assert (got === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_write(input logic [15:0] a, input logic [7:0] d);
        cpu_bus.address = a; cpu_bus.din = d; cpu_bus.w_en = 1'b1; cpu_bus.r_en = 1'b0;
        @(negedge clk);
        check("pt_wen", 32'(mem_bus.w_en), 32'd1);
        check("pt_addr", 32'(mem_bus.address), 32'(a));
        check("pt_din", 32'(mem_bus.din), 32'(d));
        check("pt_stall", 32'(cpu_stall), 32'd0);
        tick();
        cpu_bus.w_en = 1'b0;
        exp_mem[a] = d;
        $display("[TB] cpu write %04h <= %02h", a, d);
    endtask

    task automatic mem_read(input logic [15:0] a);
        cpu_bus.address = a; cpu_bus.r_en = 1'b1; cpu_bus.w_en = 1'b0;
        @(negedge clk);
        check("pt_ren", 32'(mem_bus.r_en), 32'd1);
        tick();
        cpu_bus.r_en = 1'b0;
        @(negedge clk);
        check("pt_rdata", 32'(cpu_bus.dout), 32'(exp_mem[a]));
        check("pt_stall", 32'(cpu_stall), 32'd0);
        tick();
        $display("[TB] cpu read %04h -> %02h", a, cpu_bus.dout);
    endtask

    task automatic reg_write(input int off, input logic [7:0] d);
        cpu_bus.address = BASE + 16'(off); cpu_bus.din = d; cpu_bus.w_en = 1'b1; cpu_bus.r_en = 1'b0;
        @(negedge clk);
        check("reg_wr_blocked", 32'(mem_bus.w_en), 32'd0);
        tick();
        cpu_bus.w_en = 1'b0;
    endtask

    task automatic reg_read(input int off, input logic [7:0] exp, input string tag);
        cpu_bus.address = BASE + 16'(off); cpu_bus.r_en = 1'b1; cpu_bus.w_en = 1'b0;
        @(negedge clk);
        check("reg_rd_blocked", 32'(mem_bus.r_en), 32'd0);
        tick();
        cpu_bus.r_en = 1'b0;
        @(negedge clk);
        check(tag, 32'(cpu_bus.dout), 32'(exp));
        tick();
        $display("[TB] reg read off=%0d -> %02h", off, cpu_bus.dout);
    endtask

    task automatic run_copy(input logic [15:0] src, input logic [15:0] dst, input logic [7:0] len,
                            input logic [7:0] ctrl, input bit clr_end, input bit poke);
        logic [15:0] ea [256];
        logic [15:0] sa [256];
        logic [7:0]  ed [256];
        int n, t0, tdone, rel, k;
        bit fill, writing, reading;
        n    = (len == 8'h00) ? 256 : int'(len);
        fill = FILL_EN && ctrl[2];
        for (int i = 0; i < n; i++) begin
            sa[i] = src + 16'(i);
            ea[i] = ctrl[1] ? dst : dst + 16'(i);
            ed[i] = fill ? src[7:0] : exp_mem[sa[i]];
            exp_mem[ea[i]] = ed[i];
        end
        reg_write(0, src[7:0]);
        reg_write(1, src[15:8]);
        reg_write(2, dst[7:0]);
        reg_write(3, dst[15:8]);
        reg_write(4, len);
        cpu_bus.address = BASE + 16'd5; cpu_bus.din = ctrl; cpu_bus.w_en = 1'b1;
        t0 = cyc;
        @(negedge clk);
        check("start_blocked", 32'(mem_bus.w_en), 32'd0);
        tick();
        cpu_bus.w_en = poke;
        if (poke) begin
            cpu_bus.address = BASE;
            cpu_bus.din = ~src[7:0];
        end
        tdone = t0 + (fill ? n + 1 : 2 * n + 1);
        for (int c = t0 + 1; c <= tdone; c++) begin
            done_flag_clr = clr_end && (c == tdone - 1);
            if (c == tdone) cpu_bus.w_en = 1'b0;
            rel = c - t0;
            if (fill) begin
                writing = (rel >= 1) && (rel <= n);
                reading = 1'b0;
                k = rel - 1;
            end else begin
                writing = (rel % 2 == 0) && (rel <= 2 * n);
                reading = (rel % 2 == 1) && (rel < 2 * n);
                k = writing ? (rel - 2) / 2 : (rel - 1) / 2;
            end
            @(negedge clk);
            check("stall", 32'(cpu_stall), 32'(c < tdone));
            check("done", 32'(done_flag), 32'(c >= tdone));
            check("wen", 32'(mem_bus.w_en), 32'(writing));
            check("ren", 32'(mem_bus.r_en), 32'(reading));
            if (writing) begin
                check("waddr", 32'(mem_bus.address), 32'(ea[k]));
                check("wdata", 32'(mem_bus.din), 32'(ed[k]));
            end
            if (reading) check("raddr", 32'(mem_bus.address), 32'(sa[k]));
            tick();
        end
        done_flag_clr = 1'b0;
        $display("[TB] copy src=%04h dst=%04h len=%0d ctrl=%02h start=%0d done=%0d", src, dst, n, ctrl, t0, tdone);
        reg_read(5, {5'b00000, fill, 1'b1, 1'b0}, "status");
        reg_read(0, src[7:0], "src_l_kept");
        reg_read(4, len, "len_kept");
        mem_read(ea[n - 1]);
        done_flag_clr = 1'b1;
        tick();
        done_flag_clr = 1'b0;
        @(negedge clk);
        check("done_clr", 32'(done_flag), 32'd0);
        tick();
    endtask

    initial begin
        logic [7:0] rv [5];
        logic [15:0] rsrc, rdst;
        for (int i = 0; i < 65536; i++) exp_mem[i] = init_byte(16'(i));
        cpu_bus.address = 16'h0000; cpu_bus.din = 8'h00; cpu_bus.w_en = 1'b0; cpu_bus.r_en = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("rst_stall", 32'(cpu_stall), 32'd0);
        check("rst_done", 32'(done_flag), 32'd0);
        check("rst_wen", 32'(mem_bus.w_en), 32'd0);
        check("rst_ren", 32'(mem_bus.r_en), 32'd0);
        check("rst_addr", 32'(mem_bus.address), 32'd0);
        check("rst_din", 32'(mem_bus.din), 32'd0);
        check("rst_dout", 32'(cpu_bus.dout), 32'd0);
        tick();
        rst = 1'b0;
        reg_read(1, 8'h00, "rst_src_h");
        reg_read(5, 8'h00, "rst_status");

        // Pass-through
        mem_write(16'h0010, 8'h5A);
        mem_read(16'h0010);

        // Register readback with random contents
        for (int i = 0; i < 5; i++) begin
            rv[i] = 8'($urandom);
            reg_write(i, rv[i]);
        end
        for (int i = 0; i < 5; i++) reg_read(i, rv[i], "reg_rb");

        // Block copy to VRAM
        mem_write(16'h0100, 8'h11);
        mem_write(16'h0101, 8'h22);
        mem_write(16'h0102, 8'h33);
        mem_write(16'h0103, 8'h44);
        run_copy(16'h0100, 16'h2000, 8'd4, 8'h01, 1'b0, 1'b0);

        // Source wrap with LEN=0 (256 bytes), CPU pokes ignored while stalled
        run_copy(16'hFFFF, 16'h0200, 8'd0, 8'h01, 1'b0, 1'b1);

        // Fixed destination; clear requested in the completion cycle
        run_copy(16'(16'h0600 + $urandom_range(0, 255)), 16'h100B, 8'd3, 8'h03, 1'b1, 1'b0);

        // Fill (a plain copy when fill is not built in)
        run_copy(16'h12AA, 16'h0300, 8'd5, 8'h05, 1'b0, 1'b0);

        for (int r = 0; r < 4; r++) begin
            rsrc = 16'($urandom);
            rdst = 16'h3000 + 16'($urandom_range(0, 16'h0FFF));
            run_copy(rsrc, rdst, 8'($urandom_range(1, 24)), 8'h01 | (8'($urandom) & 8'h06),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Reset in T+3 of a LEN=8 copy
        reg_write(0, 8'h00);
        reg_write(1, 8'h04);
        reg_write(2, 8'h00);
        reg_write(3, 8'h05);
        reg_write(4, 8'd8);
        cpu_bus.address = BASE + 16'd5; cpu_bus.din = 8'h01; cpu_bus.w_en = 1'b1;
        tick();
        cpu_bus.w_en = 1'b0;
        @(negedge clk);
        check("rst_t1_ren", 32'(mem_bus.r_en), 32'd1);
        tick();
        @(negedge clk);
        check("rst_t2_wen", 32'(mem_bus.w_en), 32'd1);
        check("rst_t2_wdata", 32'(mem_bus.din), 32'(exp_mem[16'h0400]));
        exp_mem[16'h0500] = exp_mem[16'h0400];
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("post_rst_wen", 32'(mem_bus.w_en), 32'd0);
            check("post_rst_stall", 32'(cpu_stall), 32'd0);
            check("post_rst_done", 32'(done_flag), 32'd0);
            tick();
        end
        $display("[TB] reset during copy at cycle %0d", cyc);
        reg_read(4, 8'h00, "post_rst_len");
        mem_read(16'h0500);
        mem_read(16'h0501);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
